// File: rtl/control_fsm_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer: opcodes, states,
// ALU op codes, datapath select codes, trap causes and instruction classes.
package control_fsm_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_RALU   = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Codes are {funct7[5], funct3} so R-type maps straight through.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;

  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_RALU,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC
  } iclass_t;

  function automatic iclass_t classify(input logic [6:0] opcode,
                                       input logic [2:0] funct3,
                                       input logic [6:0] funct7);
    iclass_t c;
    case (opcode)
      OP_RALU:   c = (funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                     ? CLS_RALU : CLS_ILLEGAL;
      OP_IALU:   c = CLS_IALU;
      OP_LOAD:   c = CLS_LOAD;
      OP_STORE:  c = CLS_STORE;
      OP_BRANCH: c = CLS_BRANCH;
      OP_JAL:    c = CLS_JAL;
      OP_JALR:   c = CLS_JALR;
      OP_LUI:    c = CLS_LUI;
      OP_AUIPC:  c = CLS_AUIPC;
      default:   c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_fsm_alu_op_decoder.sv
// Combinational instruction classifier and ALU operation decoder.
module alu_op_decoder
  import control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output iclass_t    iclass
);

  always_comb begin
    iclass = classify(opcode, funct3, funct7);
    alu_op = ALU_ADD;
    case (iclass)
      CLS_RALU: alu_op = {funct7[5], funct3};
      // Immediate forms only borrow funct7[5] for the shift-right pair.
      CLS_IALU: alu_op = {(funct3 == 3'b101) && funct7[5], funct3};
      default:  ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with memory-timeout and
// illegal-instruction traps and a retired-instruction counter.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [3:0]       alu_op,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            fsm_state;
  cause_t            cause_q;
  logic [WCNT_W-1:0] wait_cnt;
  logic [3:0]        dec_alu_op;
  iclass_t           iclass;
  logic              at_limit;

  // The former shared include is now the package; decode lives in the sub-module.
  alu_op_decoder u_alu_op_decoder (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_alu_op),
    .iclass (iclass)
  );

  assign at_limit   = (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1));
  assign state      = fsm_state;
  assign trap       = (fsm_state == TRAP);
  assign trap_cause = cause_q;

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    alu_a_sel    = A_RS1;
    alu_b_sel    = B_RS2;
    alu_op       = ALU_ADD;
    if (!rst) begin
      case (fsm_state)
        FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        EXECUTE: begin
          alu_op = dec_alu_op;
          case (iclass)
            CLS_IALU, CLS_LOAD, CLS_STORE: alu_b_sel = B_IMM;
            CLS_LUI: begin
              alu_a_sel = A_ZERO;
              alu_b_sel = B_IMM;
            end
            CLS_AUIPC: begin
              alu_a_sel = A_PC;
              alu_b_sel = B_IMM;
            end
            CLS_BRANCH: begin
              alu_a_sel = A_PC;
              alu_b_sel = B_IMM;
              pc_we     = 1'b1;
              pc_sel    = branch_taken;
            end
            CLS_JAL, CLS_JALR: begin
              alu_a_sel = (iclass == CLS_JAL) ? A_PC : A_RS1;
              alu_b_sel = B_IMM;
              reg_we    = 1'b1;
              wb_sel    = WB_PC4;
              pc_we     = 1'b1;
              pc_sel    = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (iclass == CLS_STORE);
          pc_we        = (iclass == CLS_STORE) && mem_ready;
        end
        WB: begin
          reg_we = 1'b1;
          wb_sel = (iclass == CLS_LOAD) ? WB_MEM : WB_ALU;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_state <= FETCH;
      cause_q   <= CAUSE_NONE;
      wait_cnt  <= '0;
      instret   <= '0;
    end else begin
      if (pc_we)
        instret <= instret + CNT_W'(1);
      case (fsm_state)
        FETCH: begin
          if (mem_ready) begin
            fsm_state <= DECODE;
            wait_cnt  <= '0;
          end else if (at_limit) begin
            fsm_state <= TRAP;
            cause_q   <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        DECODE: begin
          wait_cnt <= '0;
          if (iclass == CLS_ILLEGAL) begin
            fsm_state <= TRAP;
            cause_q   <= CAUSE_ILLEGAL;
          end else begin
            fsm_state <= EXECUTE;
          end
        end
        EXECUTE: begin
          wait_cnt <= '0;
          case (iclass)
            CLS_LOAD, CLS_STORE:          fsm_state <= MEM;
            CLS_BRANCH, CLS_JAL, CLS_JALR: fsm_state <= FETCH;
            default:                      fsm_state <= WB;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            fsm_state <= (iclass == CLS_STORE) ? FETCH : WB;
            wait_cnt  <= '0;
          end else if (at_limit) begin
            fsm_state <= TRAP;
            cause_q   <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        WB: begin
          fsm_state <= FETCH;
          wait_cnt  <= '0;
        end
        TRAP:    fsm_state <= TRAP;
        default: fsm_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm.
module tb_control_fsm;
  import control_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we;
  logic [1:0]  wb_sel, alu_a_sel;
  logic        alu_b_sel;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;
  logic [15:0] strb;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_ret  = 0;

  control_fsm #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .state        (state),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  assign strb = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we,
                 wb_sel, alu_a_sel, alu_b_sel, alu_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] es(input logic req, input logic we, input logic asel,
                                     input logic irwe, input logic pcwe, input logic pcsel,
                                     input logic regwe, input logic [1:0] wb,
                                     input logic [1:0] a, input logic b, input logic [3:0] op);
    return {req, we, asel, irwe, pcwe, pcsel, regwe, wb, a, b, op};
  endfunction

  task automatic set_instr(input logic [31:0] ins);
    opcode = ins[6:0];
    funct3 = ins[14:12];
    funct7 = ins[31:25];
  endtask

  // Drive one cycle's inputs, check state and strobes, advance to the next low phase.
  task automatic cyc(input string tag, input logic rdy, input logic bt,
                     input logic [2:0] st, input logic [15:0] exp);
    mem_ready    = rdy;
    branch_taken = bt;
    #1;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".strb"}, 32'(strb), 32'(exp));
    @(negedge clk);
  endtask

  task automatic fetch_decode(input string tag);
    cyc({tag, "_f"}, 1'b1, 1'b0, 3'(FETCH), es(1,0,0,1,0,0,0,2'b00,2'b00,0,4'b0000));
    cyc({tag, "_d"}, 1'b0, 1'b0, 3'(DECODE), 16'h0000);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".gate"}, 32'(strb), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    branch_taken = 1'b0;
    set_instr(32'h002082B3);
    @(negedge clk);
    #1;
    check("rst.strb", 32'(strb), 32'h0);
    check("rst.state", 32'(state), 32'(FETCH));
    check("rst.instret", instret, 32'd0);
    check("rst.cause", 32'(trap_cause), 32'd0);
    check("rst.trap", 32'(trap), 32'd0);
    rst = 1'b0;

    // ADD x5,x1,x2
    fetch_decode("add");
    cyc("add_e", 0, 0, 3'(EXECUTE), 16'h0000);
    cyc("add_w", 0, 0, 3'(WB), es(0,0,0,0,1,0,1,2'b00,2'b00,0,4'b0000));
    exp_ret++;
    check("add.instret", instret, 32'(exp_ret));
    check("add.state", 32'(state), 32'(FETCH));

    // ALU op selection
    set_instr(32'h40000033);  // SUB
    fetch_decode("sub");
    cyc("sub_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,0,0,0,2'b00,2'b00,0,4'b1000));
    cyc("sub_w", 0, 0, 3'(WB), es(0,0,0,0,1,0,1,2'b00,2'b00,0,4'b0000));
    set_instr(32'h40005013);  // SRAI
    fetch_decode("srai");
    cyc("srai_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,0,0,0,2'b00,2'b00,1,4'b1101));
    cyc("srai_w", 0, 0, 3'(WB), es(0,0,0,0,1,0,1,2'b00,2'b00,0,4'b0000));
    set_instr(32'h40000013);  // ADDI with imm[10] set: still ADD
    fetch_decode("addi");
    cyc("addi_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,0,0,0,2'b00,2'b00,1,4'b0000));
    cyc("addi_w", 0, 0, 3'(WB), es(0,0,0,0,1,0,1,2'b00,2'b00,0,4'b0000));
    set_instr(32'h00003033);  // SLTU
    fetch_decode("sltu");
    cyc("sltu_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,0,0,0,2'b00,2'b00,0,4'b0011));
    cyc("sltu_w", 0, 0, 3'(WB), es(0,0,0,0,1,0,1,2'b00,2'b00,0,4'b0000));
    set_instr(32'h00000037);  // LUI
    fetch_decode("lui");
    cyc("lui_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,0,0,0,2'b00,2'b10,1,4'b0000));
    cyc("lui_w", 0, 0, 3'(WB), es(0,0,0,0,1,0,1,2'b00,2'b00,0,4'b0000));
    set_instr(32'h00000017);  // AUIPC
    fetch_decode("auipc");
    cyc("auipc_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,0,0,0,2'b00,2'b01,1,4'b0000));
    cyc("auipc_w", 0, 0, 3'(WB), es(0,0,0,0,1,0,1,2'b00,2'b00,0,4'b0000));
    exp_ret += 6;
    check("alu.instret", instret, 32'(exp_ret));

    // SW with three wait cycles
    set_instr(32'h00002023);
    fetch_decode("sw");
    cyc("sw_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,0,0,0,2'b00,2'b00,1,4'b0000));
    for (int i = 0; i < 3; i++)
      cyc("sw_mw", 0, 0, 3'(MEM), es(1,1,1,0,0,0,0,2'b00,2'b00,0,4'b0000));
    cyc("sw_mr", 1, 0, 3'(MEM), es(1,1,1,0,1,0,0,2'b00,2'b00,0,4'b0000));
    exp_ret++;
    check("sw.state", 32'(state), 32'(FETCH));
    check("sw.instret", instret, 32'(exp_ret));

    // Branches and jumps
    set_instr(32'h00000063);
    fetch_decode("beqt");
    cyc("beqt_e", 0, 1, 3'(EXECUTE), es(0,0,0,0,1,1,0,2'b00,2'b01,1,4'b0000));
    check("beqt.state", 32'(state), 32'(FETCH));
    fetch_decode("beqn");
    cyc("beqn_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,1,0,0,2'b00,2'b01,1,4'b0000));
    check("beqn.state", 32'(state), 32'(FETCH));
    set_instr(32'h0000006F);
    fetch_decode("jal");
    cyc("jal_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,1,1,1,2'b10,2'b01,1,4'b0000));
    set_instr(32'h00000067);
    fetch_decode("jalr");
    cyc("jalr_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,1,1,1,2'b10,2'b00,1,4'b0000));
    exp_ret += 4;
    check("br.instret", instret, 32'(exp_ret));

    // LW zero-wait
    set_instr(32'h00002003);
    fetch_decode("lw");
    cyc("lw_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,0,0,0,2'b00,2'b00,1,4'b0000));
    cyc("lw_m", 1, 0, 3'(MEM), es(1,0,1,0,0,0,0,2'b00,2'b00,0,4'b0000));
    cyc("lw_w", 0, 0, 3'(WB), es(0,0,0,0,1,0,1,2'b01,2'b00,0,4'b0000));
    exp_ret++;
    check("lw.instret", instret, 32'(exp_ret));

    // Illegal R-type funct7
    set_instr(32'h02000033);
    fetch_decode("mul");
    cyc("mul_t", 1, 0, 3'(TRAP), 16'h0000);
    check("mul.trap", 32'(trap), 32'd1);
    check("mul.cause", 32'(trap_cause), 32'd1);
    do_reset("mul_rst");
    check("mul_rst.cause", 32'(trap_cause), 32'd0);
    check("mul_rst.instret", instret, 32'd0);

    // Illegal opcode, trap held for 20 cycles despite opcode/ready changes
    set_instr(32'h0000007F);
    fetch_decode("ill");
    for (int i = 0; i < 20; i++) begin
      if (i == 10) set_instr(32'h002082B3);
      cyc("ill_t", 1, 1, 3'(TRAP), 16'h0000);
    end
    check("ill.trap", 32'(trap), 32'd1);
    check("ill.cause", 32'(trap_cause), 32'd1);
    check("ill.instret", instret, 32'd0);
    do_reset("ill_rst");
    check("ill_rst.state", 32'(state), 32'(FETCH));
    check("ill_rst.cause", 32'(trap_cause), 32'd0);
    check("ill_rst.trap", 32'(trap), 32'd0);

    // Fetch timeout
    set_instr(32'h002082B3);
    for (int i = 0; i < 16; i++)
      cyc("to_w", 0, 0, 3'(FETCH), es(1,0,0,0,0,0,0,2'b00,2'b00,0,4'b0000));
    check("to.state", 32'(state), 32'(TRAP));
    check("to.cause", 32'(trap_cause), 32'd2);
    do_reset("to_rst");

    // Ready on the limit cycle wins
    for (int i = 0; i < 15; i++)
      cyc("lim_w", 0, 0, 3'(FETCH), es(1,0,0,0,0,0,0,2'b00,2'b00,0,4'b0000));
    cyc("lim_r", 1, 0, 3'(FETCH), es(1,0,0,1,0,0,0,2'b00,2'b00,0,4'b0000));
    check("lim.state", 32'(state), 32'(DECODE));
    check("lim.cause", 32'(trap_cause), 32'd0);
    cyc("lim_d", 0, 0, 3'(DECODE), 16'h0000);
    cyc("lim_e", 0, 0, 3'(EXECUTE), 16'h0000);
    cyc("lim_wb", 0, 0, 3'(WB), es(0,0,0,0,1,0,1,2'b00,2'b00,0,4'b0000));
    exp_ret++;
    check("lim.instret", instret, 32'(exp_ret));

    // Reset in the middle of a LW memory wait
    set_instr(32'h00002003);
    fetch_decode("lwr");
    cyc("lwr_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,0,0,0,2'b00,2'b00,1,4'b0000));
    cyc("lwr_m", 0, 0, 3'(MEM), es(1,0,1,0,0,0,0,2'b00,2'b00,0,4'b0000));
    do_reset("lwr_rst");
    check("lwr.state", 32'(state), 32'(FETCH));
    check("lwr.instret", instret, 32'd0);

    // Memory-stage timeout on a load
    fetch_decode("lwt");
    cyc("lwt_e", 0, 0, 3'(EXECUTE), es(0,0,0,0,0,0,0,2'b00,2'b00,1,4'b0000));
    for (int i = 0; i < 16; i++)
      cyc("lwt_m", 0, 0, 3'(MEM), es(1,0,1,0,0,0,0,2'b00,2'b00,0,4'b0000));
    check("lwt.state", 32'(state), 32'(TRAP));
    check("lwt.cause", 32'(trap_cause), 32'd2);
    check("lwt.instret", instret, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
